// File: rtl/watch_date_pkg.sv
// watch_date_pkg
// Shared definitions for the calendar stage: field widths, the packed
// bin_date layout, month and weekday constants, and a weekday helper.
// No ports (package).
package watch_date_pkg;

  localparam int YEAR_W  = 7;
  localparam int MONTH_W = 4;
  localparam int DAY_W   = 5;
  localparam int WDAY_W  = 3;

  // Bit offsets of each field inside bin_date.
  localparam int DAY_LSB   = 0;
  localparam int MONTH_LSB = 5;
  localparam int YEAR_LSB  = 9;

  localparam logic [MONTH_W-1:0] JAN = 4'd1;
  localparam logic [MONTH_W-1:0] FEB = 4'd2;
  localparam logic [MONTH_W-1:0] MAR = 4'd3;
  localparam logic [MONTH_W-1:0] APR = 4'd4;
  localparam logic [MONTH_W-1:0] MAY = 4'd5;
  localparam logic [MONTH_W-1:0] JUN = 4'd6;
  localparam logic [MONTH_W-1:0] JUL = 4'd7;
  localparam logic [MONTH_W-1:0] AUG = 4'd8;
  localparam logic [MONTH_W-1:0] SEP = 4'd9;
  localparam logic [MONTH_W-1:0] OCT = 4'd10;
  localparam logic [MONTH_W-1:0] NOV = 4'd11;
  localparam logic [MONTH_W-1:0] DEC = 4'd12;

  localparam logic [WDAY_W-1:0] SUN = 3'd0;
  localparam logic [WDAY_W-1:0] MON = 3'd1;
  localparam logic [WDAY_W-1:0] TUE = 3'd2;
  localparam logic [WDAY_W-1:0] WED = 3'd3;
  localparam logic [WDAY_W-1:0] THU = 3'd4;
  localparam logic [WDAY_W-1:0] FRI = 3'd5;
  localparam logic [WDAY_W-1:0] SAT = 3'd6;

  localparam logic [YEAR_W-1:0] YEAR_MAX = 7'd99;

  // Packed view of bin_date; the member order reproduces the bit offsets above.
  typedef struct packed {
    logic [YEAR_W-1:0]  year;
    logic [MONTH_W-1:0] month;
    logic [DAY_W-1:0]   day;
  } date_t;

  // Weekday successor, Saturday wraps to Sunday.
  function automatic logic [WDAY_W-1:0] next_wday(input logic [WDAY_W-1:0] w);
    logic [WDAY_W-1:0] n;
    if (w == SAT) begin
      n = SUN;
    end else begin
      n = w + 3'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/watch_date_if.sv
// watch_date_if
// Bundles the calendar stage's pulse/load inputs and date outputs.
//   master : setting logic / time counter side (drives en_day, set_date, bin_*)
//   slave  : watch_date itself (drives year, month, day, wday, en_year, set_err)
interface watch_date_if;
  import watch_date_pkg::*;

  logic                  en_day;
  logic                  set_date;
  logic [15:0]           bin_date;
  logic [WDAY_W-1:0]     bin_wday;
  logic [YEAR_W-1:0]     year;
  logic [MONTH_W-1:0]    month;
  logic [DAY_W-1:0]      day;
  logic [WDAY_W-1:0]     wday;
  logic                  en_year;
  logic                  set_err;

  modport master (
    output en_day, set_date, bin_date, bin_wday,
    input  year, month, day, wday, en_year, set_err
  );

  modport slave (
    input  en_day, set_date, bin_date, bin_wday,
    output year, month, day, wday, en_year, set_err
  );

endinterface

// File: rtl/watch_date_month_len.sv
// month_len
// Purely combinational month length lookup.
//   month    in  : month number (1..12 legal)
//   year     in  : two-digit year offset from 2000
//   days     out : days in that month (0 when month is illegal)
//   month_ok out : month lies in 1..12
// Every year divisible by four is leap; in 2000..2099 that includes 2000.
module month_len
  import watch_date_pkg::*;
(
  input  logic [MONTH_W-1:0] month,
  input  logic [YEAR_W-1:0]  year,
  output logic [DAY_W-1:0]   days,
  output logic               month_ok
);

  // Month length table with February leap adjustment.
  always_comb begin
    days     = 5'd0;
    month_ok = 1'b1;
    case (month)
      JAN, MAR, MAY, JUL, AUG, OCT, DEC: days = 5'd31;
      APR, JUN, SEP, NOV:                days = 5'd30;
      FEB: begin
        if (year[1:0] == 2'b00) begin
          days = 5'd29;
        end else begin
          days = 5'd28;
        end
      end
      default: begin
        days     = 5'd0;
        month_ok = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/watch_date.sv
// watch_date
// Calendar stage behind the time-of-day counter. Advances day/month/year/
// weekday on each en_day pulse and accepts validated date loads.
//   clk  in : system clock
//   rst  in : asynchronous active-low reset
//   bus     : watch_date_if.slave
//             in  en_day, set_date, bin_date {year,month,day}, bin_wday
//             out year, month, day, wday, en_year (Dec 31 -> Jan 1 pulse),
//                 set_err (rejected load pulse)
// Priority: set_date, then en_day, then hold. All outputs are registered.
module watch_date
  import watch_date_pkg::*;
#(
  parameter int RST_YEAR  = 0,
  parameter int RST_MONTH = 1,
  parameter int RST_DAY   = 1,
  parameter int RST_WDAY  = 6
) (
  input  logic         clk,
  input  logic         rst,
  watch_date_if.slave  bus
);

  localparam logic [YEAR_W-1:0]  RST_YEAR_L  = RST_YEAR[YEAR_W-1:0];
  localparam logic [MONTH_W-1:0] RST_MONTH_L = RST_MONTH[MONTH_W-1:0];
  localparam logic [DAY_W-1:0]   RST_DAY_L   = RST_DAY[DAY_W-1:0];
  localparam logic [WDAY_W-1:0]  RST_WDAY_L  = RST_WDAY[WDAY_W-1:0];

  logic [YEAR_W-1:0]  year_q,  year_d;
  logic [MONTH_W-1:0] month_q, month_d;
  logic [DAY_W-1:0]   day_q,   day_d;
  logic [WDAY_W-1:0]  wday_q,  wday_d;
  logic               en_year_q, en_year_d;
  logic               set_err_q, set_err_d;

  date_t              ld_s;
  logic [DAY_W-1:0]   cur_days_s, ld_days_s;
  logic               cur_month_ok_s, ld_month_ok_s;
  logic               ld_ok_s;
  logic               last_day_s;

  assign ld_s = date_t'(bus.bin_date);

  // Length of the month currently held, used by the advance path.
  month_len u_cur_len (
    .month    (month_q),
    .year     (year_q),
    .days     (cur_days_s),
    .month_ok (cur_month_ok_s)
  );

  // Length of the month being loaded; leap check uses the incoming year.
  month_len u_ld_len (
    .month    (ld_s.month),
    .year     (ld_s.year),
    .days     (ld_days_s),
    .month_ok (ld_month_ok_s)
  );

  assign ld_ok_s = (ld_s.year <= YEAR_MAX) && ld_month_ok_s &&
                   (ld_s.day != 5'd0) && (ld_s.day <= ld_days_s) &&
                   (bus.bin_wday <= SAT);

  // An illegal month cannot occur in practice; treating it as month end
  // keeps the advance path well defined anyway.
  assign last_day_s = !cur_month_ok_s || (day_q >= cur_days_s);

  // Next-state: load beats advance beats hold; pulses default low.
  always_comb begin
    year_d    = year_q;
    month_d   = month_q;
    day_d     = day_q;
    wday_d    = wday_q;
    en_year_d = 1'b0;
    set_err_d = 1'b0;
    if (bus.set_date) begin
      if (ld_ok_s) begin
        year_d  = ld_s.year;
        month_d = ld_s.month;
        day_d   = ld_s.day;
        wday_d  = bus.bin_wday;
      end else begin
        set_err_d = 1'b1;
      end
    end else if (bus.en_day) begin
      wday_d = next_wday(wday_q);
      if (!last_day_s) begin
        day_d = day_q + 5'd1;
      end else if (month_q < DEC) begin
        day_d   = 5'd1;
        month_d = month_q + 4'd1;
      end else begin
        day_d     = 5'd1;
        month_d   = JAN;
        en_year_d = 1'b1;
        if (year_q == YEAR_MAX) begin
          year_d = 7'd0;
        end else begin
          year_d = year_q + 7'd1;
        end
      end
    end else begin
      year_d = year_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      year_q    <= RST_YEAR_L;
      month_q   <= RST_MONTH_L;
      day_q     <= RST_DAY_L;
      wday_q    <= RST_WDAY_L;
      en_year_q <= 1'b0;
      set_err_q <= 1'b0;
    end else begin
      year_q    <= year_d;
      month_q   <= month_d;
      day_q     <= day_d;
      wday_q    <= wday_d;
      en_year_q <= en_year_d;
      set_err_q <= set_err_d;
    end
  end

  assign bus.year    = year_q;
  assign bus.month   = month_q;
  assign bus.day     = day_q;
  assign bus.wday    = wday_q;
  assign bus.en_year = en_year_q;
  assign bus.set_err = set_err_q;

endmodule

// File: tb/tb_watch_date.sv
// tb_watch_date
// Scoreboard bench: the driver issues one stimulus per cycle and pushes the
// calendar outcome predicted by a plain-arithmetic date model; a monitor pops
// one entry after every clock edge and compares it with the DUT outputs.
module tb_watch_date;

  logic clk;
  logic rst;

  watch_date_if bus ();

  watch_date dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int    y;
    int    m;
    int    d;
    int    w;
    int    ey;
    int    se;
    string tag;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Calendar model state.
  int m_y = 0;
  int m_m = 1;
  int m_d = 1;
  int m_w = 6;

  function automatic int dim(input int mo, input int yr);
    if (mo == 2) return ((yr % 4) == 0) ? 29 : 28;
    if (mo == 4 || mo == 6 || mo == 9 || mo == 11) return 30;
    return 31;
  endfunction

  task automatic check(input string tag, input int ey, input int em, input int ed,
                       input int ew, input int eey, input int ese);
    int ay, am, ad, aw, aey, ase;
    ay = int'(bus.year); am = int'(bus.month); ad = int'(bus.day);
    aw = int'(bus.wday); aey = int'(bus.en_year); ase = int'(bus.set_err);
    checks++;
    if (ay != ey || am != em || ad != ed || aw != ew || aey != eey || ase != ese) begin
      errors++;
      $display("FAIL %s: got %0d-%0d-%0d w%0d en_year=%0d set_err=%0d, want %0d-%0d-%0d w%0d en_year=%0d set_err=%0d",
               tag, ay, am, ad, aw, aey, ase, ey, em, ed, ew, eey, ese);
    end
  endtask

  // One stimulus cycle: drive at the falling edge, predict the next state.
  task automatic drive(input bit sd, input bit ed, input int by, input int bm,
                       input int bd, input int bw, input string tag);
    exp_t e;
    bit   ok;
    @(negedge clk);
    bus.set_date = sd;
    bus.en_day   = ed;
    bus.bin_date = {7'(by), 4'(bm), 5'(bd)};
    bus.bin_wday = 3'(bw);
    e.ey = 0;
    e.se = 0;
    if (sd) begin
      ok = (by <= 99) && (bm >= 1) && (bm <= 12) && (bd >= 1) &&
           (bd <= dim(bm, by)) && (bw <= 6);
      if (ok) begin
        m_y = by; m_m = bm; m_d = bd; m_w = bw;
      end else begin
        e.se = 1;
      end
    end else if (ed) begin
      m_w = (m_w + 1) % 7;
      m_d = m_d + 1;
      if (m_d > dim(m_m, m_y)) begin
        m_d = 1;
        m_m = m_m + 1;
        if (m_m > 12) begin
          m_m = 1;
          m_y = (m_y + 1) % 100;
          e.ey = 1;
        end
      end
    end
    e.y = m_y; e.m = m_m; e.d = m_d; e.w = m_w; e.tag = tag;
    q.push_back(e);
  endtask

  task automatic idle(input string tag);
    drive(1'b0, 1'b0, 0, 0, 0, 0, tag);
  endtask

  task automatic load(input int by, input int bm, input int bd, input int bw,
                      input string tag);
    drive(1'b1, 1'b0, by, bm, bd, bw, tag);
  endtask

  task automatic advance(input string tag);
    drive(1'b0, 1'b1, 0, 0, 0, 0, tag);
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries pending, want 0", q.size());
      q.delete();
    end
  endtask

  // Monitor: one output sample per clock edge while predictions are queued.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check(e.tag, e.y, e.m, e.d, e.w, e.ey, e.se);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int r;
    rst          = 1'b0;
    bus.en_day   = 1'b0;
    bus.set_date = 1'b0;
    bus.bin_date = 16'd0;
    bus.bin_wday = 3'd0;
    #12;
    check("reset", 0, 1, 1, 6, 0, 0);
    @(negedge clk);
    rst = 1'b1;

    // Directed cases.
    idle("hold0"); idle("hold1"); idle("hold2");
    load(23, 1, 31, 2, "ld_23_01_31");  advance("adv_jan31");
    load(23, 2, 28, 2, "ld_23_02_28");  advance("adv_feb28_nonleap");
    load(24, 2, 28, 3, "ld_24_02_28");  advance("adv_feb28_leap"); advance("adv_feb29");
    load(99, 12, 31, 4, "ld_99_12_31"); advance("adv_year_wrap"); idle("en_year_clear");
    load(0, 2, 28, 5, "ld_00_02_28");   advance("adv_2000_leap");
    load(23, 2, 29, 2, "ld_bad_feb29"); idle("set_err_clear");
    load(23, 13, 1, 1, "ld_bad_month13");
    load(23, 5, 0, 1, "ld_bad_day0");
    load(23, 4, 31, 1, "ld_bad_apr31");
    load(100, 1, 1, 1, "ld_bad_year100");
    load(23, 1, 1, 7, "ld_bad_wday7");
    load(23, 0, 1, 1, "ld_bad_month0");
    drive(1'b1, 1'b1, 10, 6, 15, 2, "ld_beats_en_day");
    idle("after_coincident");
    load(23, 6, 30, 6, "ld_23_06_30"); advance("adv_jun30"); advance("adv_b2b");

    // Randomized traffic, biased toward month and year ends.
    for (int i = 0; i < 500; i++) begin
      r = $urandom_range(0, 11);
      case (r)
        0: load($urandom_range(0, 110), $urandom_range(0, 13), $urandom_range(0, 31),
                $urandom_range(0, 7), "rnd_load");
        1: load($urandom_range(0, 99), $urandom_range(1, 12), $urandom_range(26, 31),
                $urandom_range(0, 6), "rnd_load_end");
        2: load(99, 12, $urandom_range(28, 31), $urandom_range(0, 6), "rnd_load_dec");
        3: drive(1'b1, 1'b1, $urandom_range(0, 99), $urandom_range(1, 12),
                 $urandom_range(1, 28), $urandom_range(0, 6), "rnd_load_and_day");
        4, 5, 6, 7, 8: advance("rnd_adv");
        default: idle("rnd_idle");
      endcase
    end
    drain();

    // Reset in the middle of activity with pulses pending.
    @(negedge clk);
    bus.set_date = 1'b1;
    bus.en_day   = 1'b1;
    bus.bin_date = {7'd50, 4'd7, 5'd4};
    bus.bin_wday = 3'd1;
    #2;
    rst = 1'b0;
    #1;
    check("async_reset", 0, 1, 1, 6, 0, 0);
    @(posedge clk);
    #1;
    check("reset_held", 0, 1, 1, 6, 0, 0);
    @(negedge clk);
    bus.set_date = 1'b0;
    bus.en_day   = 1'b0;
    rst = 1'b1;
    m_y = 0; m_m = 1; m_d = 1; m_w = 6;
    idle("post_reset_hold");
    advance("post_reset_adv");
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/watch_date.md
Name: watch_date

Overview:
Calendar stage directly downstream of the time-of-day counter. It consumes the one-cycle day-rollover pulse (en_day) that the time counter produces at 23:59:59→00:00:00. It advances day, month, two-digit year (2000–2099) and weekday, with leap-year handling. It also accepts a validated load from the setting logic and feeds the display/alarm stages.

Parameters:
RST_YEAR, 0, year (0–99, offset from 2000) loaded on reset
RST_MONTH, 1, month (1–12) loaded on reset
RST_DAY, 1, day (1–31) loaded on reset
RST_WDAY, 6, weekday loaded on reset (0=Sun … 6=Sat; 2000-01-01 = Sat)

Ports:
clk  in  1  system clock, the single clock of the block
rst  in  1  asynchronous, active-low reset
en_day  in  1  one-cycle day-advance pulse from the time counter
set_date  in  1  load request; sampled every cycle
bin_date  in  16  load value {year[6:0], month[3:0], day[4:0]}
bin_wday  in  3  weekday loaded with bin_date
year  out  7  0–99
month  out  4  1–12
day  out  5  1–31
wday  out  3  0–6
en_year  out  1  one-cycle pulse on Dec 31 → Jan 1
set_err  out  1  one-cycle pulse when a load is rejected

Behaviour:
- One clock (clk); reset is asynchronous and active-low (rst). All state is registered.
- Reset values: year=RST_YEAR, month=RST_MONTH, day=RST_DAY, wday=RST_WDAY, en_year=0, set_err=0.
- Days in month:
  - 31 for months 1, 3, 5, 7, 8, 10, 12.
  - 30 for months 4, 6, 9, 11.
  - Feb = 29 if year[1:0]==0, else 28. Year 00 (2000) is a leap year.
- Priority each cycle: set_date > en_day > hold.
- set_date=1:
  - Valid load: year ≤ 99, 1 ≤ month ≤ 12, 1 ≤ day ≤ days_in_month(month, year), bin_wday ≤ 6. Leap check uses the incoming year.
  - If valid, load all four fields on the next edge; set_err=0.
  - If invalid, state is unchanged and set_err=1 for exactly that cycle.
  - en_year=0 in either case. A coincident en_day is discarded.
- en_day=1 and set_date=0, single-cycle update, outputs change on that edge:
  - wday: wraps 6→0, else +1.
  - If day < days_in_month: day+1.
  - Else if month < 12: day=1, month+1.
  - Else: day=1, month=1, year = (year==99) ? 0 : year+1, en_year=1 for one cycle.
- en_year and set_err default to 0 every cycle they are not asserted. Back-to-back en_day pulses advance one day per cycle.
- Latency: one clock from input pulse to updated outputs. No internal pipelining.
- State is never out of range after reset or a valid load, so no recovery logic is required.
- Reset asserted mid-operation: immediate return to reset values regardless of pending pulses.

Decomposition:
- Shared package:
  - Month constants JAN…DEC.
  - Weekday constants SUN…SAT.
  - Field widths: YEAR_W=7, MONTH_W=4, DAY_W=5, WDAY_W=3.
  - Packed bin_date layout: field offsets day [4:0], month [8:5], year [15:9].
- One combinational sub-module, month_len:
  - Inputs: month, year.
  - Outputs: days (5 bits) and a month_ok flag.
  - Instantiated twice: once for the current state (advance path), once for bin_date (load validation).

Test Plan:
- Reset with default parameters → 00-01-01, wday=6, en_year=0, set_err=0. Release and drive no pulses → values hold.
- Load 23-01-31 wday=2, pulse en_day → 23-02-01, wday=3.
- Load 23-02-28 wday=2, pulse en_day → 23-03-01, wday=3.
- Load 24-02-28 wday=3, pulse en_day twice → 24-02-29 wday=4, then 24-03-01 wday=5.
- Load 99-12-31 wday=4, pulse en_day → 00-01-01, wday=5, en_year high for exactly one cycle.
- Load 23-02-29 → set_err high one cycle, date unchanged.
- Load month 13 or day 0 → set_err, date unchanged.
- Assert set_date with valid 10-06-15 and en_day in the same cycle → 10-06-15 loaded, no advance, en_year=0.
